// File: rtl/gray_conv_arbiter.sv
// Two-requester arbiter that shares one registered binary-to-Gray stage with a valid/ready output.
// Define GRAY_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module gray_conv_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] bin0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] bin1,
    output logic             gnt1,
    output logic [WIDTH-1:0] gray_out,
    output logic             gray_valid,
    output logic             gray_src,
    input  logic             gray_ready,
    output logic             busy,
    output logic [7:0]       conv_count
);

    typedef enum logic [1:0] {StIdle, StConv, StHold} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             src_q, src_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             valid_q, valid_d;
    logic             gsrc_q, gsrc_d;
    logic [7:0]       count_q, count_d;
    logic             win;

`ifdef GRAY_ARB_RR_EN
    logic last_q, last_d;

    // On contention the requester that did not win last time goes next.
    always_comb begin
        if (req0 && req1) win = ~last_q;
        else              win = ~req0;
    end
`else
    assign win = ~req0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req0 || req1) state_d = StConv;
            StConv:  state_d = StHold;
            StHold:  if (gray_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bin_d   = bin_q;
        src_d   = src_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        gray_d  = gray_q;
        valid_d = valid_q;
        gsrc_d  = gsrc_q;
        count_d = count_q;
`ifdef GRAY_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    bin_d  = win ? bin1 : bin0;
                    src_d  = win;
                    gnt0_d = ~win;
                    gnt1_d = win;
`ifdef GRAY_ARB_RR_EN
                    last_d = win;
`endif
                end
            end
            StConv: begin
                gray_d  = bin_q ^ (bin_q >> 1);
                gsrc_d  = src_q;
                valid_d = 1'b1;
            end
            StHold: begin
                if (gray_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            src_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            gsrc_q  <= 1'b0;
            count_q <= 8'd0;
`ifdef GRAY_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            bin_q   <= bin_d;
            src_q   <= src_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            gray_q  <= gray_d;
            valid_q <= valid_d;
            gsrc_q  <= gsrc_d;
            count_q <= count_d;
`ifdef GRAY_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign gray_out   = gray_q;
    assign gray_valid = valid_q;
    assign gray_src   = gsrc_q;
    assign busy       = (state_q != StIdle);
    assign conv_count = count_q;

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Shares a single registered binary-to-Gray conversion stage between two requesters. Arbitrates requests (round-robin or fixed priority), captures the winner's binary word, and presents the Gray-coded result downstream with a valid/ready handshake. Keeps a wrapping count of completed conversions. Sits between binary producers (counters, address generators) and a consumer that needs Gray-coded values.

## Interface
Parameters:
- WIDTH, 4, bit width of binary input and Gray output (>= 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 request, level, held until gnt0 seen
- bin0  input  WIDTH  requester 0 binary word, stable while req0 high
- gnt0  output  1  one-cycle grant pulse to requester 0
- req1  input  1  requester 1 request
- bin1  input  WIDTH  requester 1 binary word
- gnt1  output  1  one-cycle grant pulse to requester 1
- gray_out  output  WIDTH  registered Gray result
- gray_valid  output  1  gray_out holds a result
- gray_src  output  1  requester index of current result
- gray_ready  input  1  downstream accepts result
- busy  output  1  high whenever state != IDLE
- conv_count  output  8  completed transfers, wraps

## Operation
- FSM states: IDLE, CONV, HOLD. Reset state IDLE.
- IDLE: if req0 or req1 at a clock edge -> pick winner, latch its bin into internal bin_q, assert its gnt for the next cycle, record winner in src_q, go CONV. No request -> stay IDLE.
- CONV: at next edge gray_out <= bin_q ^ (bin_q >> 1), gray_src <= src_q, gray_valid <= 1, gnt cleared, go HOLD.
- HOLD: gray_out, gray_src, gray_valid held stable. At an edge with gray_ready=1: gray_valid <= 0, conv_count <= conv_count + 1 (mod 256), go IDLE. gray_ready=0: stay.
- Requests are sampled only in IDLE; requests arriving in CONV/HOLD wait.
- Requester must drop req on the edge after it sees gnt; a req still high on the next IDLE cycle is a new request.
- Round-robin pointer last_q updated on each grant; when both request, grant goes to the requester not equal to last_q. Single request always granted.
- gray_ready ignored outside HOLD.
- Reset values: gnt0=0, gnt1=0, gray_out=0, gray_valid=0, gray_src=0, busy=0, conv_count=0, last_q=1 (so requester 0 wins first contention), state IDLE.
- Reset asserted mid-operation (any state) clears everything immediately, asynchronously; no transfer counted, pending grant lost.

## Timing
- Request sampled at edge E0 -> gnt high cycle E0..E1 -> gray_valid high from E1.
- With gray_ready held high: valid for exactly one cycle, transfer at E2, IDLE after E2, next grant at E3 earliest. Peak throughput: one conversion per 3 cycles.
- Latency request-edge to gray_valid: 2 edges (E0 grant, E1 result).
- conv_count increments on the same edge that clears gray_valid.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- GRAY_ARB_RR_EN defined: round-robin arbitration as above.
- GRAY_ARB_RR_EN undefined: fixed priority, requester 0 always wins contention; last_q not implemented. Single-request behaviour, timing and handshake identical.

## Test plan
- Reset: hold rst_n low, drive random inputs -> all outputs 0, busy=0; release, no req -> stays idle.
- Single request: req0=1, bin0=0101 -> gnt0 one cycle, then gray_out=0111, gray_valid=1, gray_src=0; gray_ready=1 -> valid drops, conv_count=1.
- Contention (RR_EN): req0 and req1 held high continuously, bin0=1011, bin1=1111 -> grants alternate 0,1,0,1; outputs 1110 (src 0) and 1000 (src 1); without RR_EN -> requester 0 granted first, requester 1 only after req0 drops.
- Backpressure: bin1=0110, gray_ready=0 for 5 cycles after valid -> gray_out=0101, gray_src=1, valid stable all 5 cycles, no new grant while req0 pending; ready=1 -> transfer, then req0 granted.
- Counter wrap: 256 back-to-back transfers -> conv_count reaches 255 then 0.
- Reset mid-HOLD: gray_valid=1, gray_ready=0, pulse rst_n low -> valid, gray_out, conv_count to 0 immediately, state IDLE, no transfer counted.
